// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Parity framing is selected at build time by the UART_PARITY_EN macro.
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned BUS_W    = 32;
  localparam int unsigned BAUD_W   = 16;
  localparam int unsigned BIT_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [2:0] OFS_TXDATA = 3'h0;
  localparam logic [2:0] OFS_STATUS = 3'h4;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_EMPTY = 1;
  localparam int unsigned ST_FULL  = 2;
  localparam int unsigned ST_OVF   = 3;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty derive from pointer state only.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  // Storage needs no reset; entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA pushes into a FIFO, STATUS reports state,
// serializer drives 8N1 (or 8E1 when UART_PARITY_EN is defined) onto tx.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [BUS_W-1:0]  a,
  input  logic [BUS_W-1:0]  wd,
  output logic [BUS_W-1:0]  rd,
  output logic              hit,
  output logic              tx,
  output logic              tx_busy
);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = CLK_DIV - BAUD_W'(1);

  tx_state_e             state_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BIT_IDX_W-1:0]  bit_idx_q;
  logic [DATA_W-1:0]     shift_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  ovf_q;
`ifdef UART_PARITY_EN
  logic                  par_q;
`endif

  logic                  wr_txdata_c;
  logic                  wr_status_c;
  logic                  fifo_push_c;
  logic                  fifo_pop_c;
  logic [DATA_W-1:0]     fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [BUS_W-1:0]      status_c;
  logic                  unused_bits;

  // Address decode: one 8-byte window, offset selected by a[2].
  assign hit         = (a[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata_c = we && hit && (a[2] == OFS_TXDATA[2]);
  assign wr_status_c = we && hit && (a[2] == OFS_STATUS[2]);
  assign fifo_push_c = wr_txdata_c && !fifo_full;
  assign fifo_pop_c  = (state_q == IDLE) && !fifo_empty;
  assign unused_bits = ^{wd[31:8], a[1:0]};

  always_comb begin
    status_c           = '0;
    status_c[ST_BUSY]  = busy_q;
    status_c[ST_EMPTY] = fifo_empty;
    status_c[ST_FULL]  = fifo_full;
    status_c[ST_OVF]   = ovf_q;
  end

  assign rd      = (hit && (a[2] == OFS_STATUS[2])) ? status_c : '0;
  assign tx      = tx_q;
  assign tx_busy = busy_q;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_c),
    .pop   (fifo_pop_c),
    .din   (wd[DATA_W-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A store to a full FIFO is dropped and latched as overflow until software clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (wr_txdata_c && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (wr_status_c && wd[ST_OVF]) begin
      ovf_q <= 1'b0;
    end
  end

  // Serializer FSM; tx and tx_busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
`ifdef UART_PARITY_EN
            par_q   <= even_parity(fifo_dout);
`endif
            baud_q  <= BAUD_RELOAD;
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (baud_q == '0) begin
            baud_q    <= BAUD_RELOAD;
            bit_idx_q <= '0;
            state_q   <= DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_RELOAD;
            if (bit_idx_q == BIT_IDX_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
              state_q <= PARITY;
              tx_q    <= par_q;
`else
              state_q <= STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        PARITY: begin
          if (baud_q == '0) begin
            baud_q  <= BAUD_RELOAD;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (baud_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            baud_q <= baud_q - BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed MMIO steps, serial monitor checked against a byte scoreboard.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam int          DIV    = 4;
`ifdef UART_PARITY_EN
  localparam int          NB     = 11;
`else
  localparam int          NB     = 10;
`endif
  localparam int          FCYC   = NB * DIV;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;
  logic        tx_busy;

  int          chk_cnt;
  int          pass_cnt;
  int          frames_seen;
  bit          mon_en;
  logic [7:0]  sb[$];

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (16'(DIV)),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .a       (a),
    .wd      (wd),
    .rd      (rd),
    .hit     (hit),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected line level for frame bit k (0=start, 1..8 data LSB first, then parity/stop).
  function automatic logic fbit(input logic [7:0] b, input int k);
    logic [7:0] v;
    v = b;
    if (k == 0) return 1'b0;
    if (k <= 8) return v[k-1];
`ifdef UART_PARITY_EN
    if (k == 9) return ^v;
`endif
    return 1'b1;
  endfunction

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    we = 1'b0; a = addr;
    #1;
    check(tag, rd, exp);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(tx_busy), 32'd0);
  endtask

  // Two back-to-back stores; checks exact tx/tx_busy waveform including the one idle gap cycle.
  task automatic burst2_check(input logic [7:0] b0, input logic [7:0] b1);
    logic exp_tx;
    logic exp_b;
    sb.push_back(b0);
    sb.push_back(b1);
    @(negedge clk);
    we = 1'b1; a = BASE; wd = {24'h0, b0};
    @(negedge clk);
    check("lat_tx_before_pop", 32'(tx), 32'd1);
    check("lat_busy_before_pop", 32'(tx_busy), 32'd0);
    wd = {24'h0, b1};
    @(negedge clk);
    we = 1'b0;
    for (int c = 1; c <= 2 * FCYC + 1; c++) begin
      if (c <= FCYC) begin
        exp_tx = fbit(b0, (c - 1) / DIV); exp_b = 1'b1;
      end else if (c == FCYC + 1) begin
        exp_tx = 1'b1; exp_b = 1'b0;
      end else begin
        exp_tx = fbit(b1, (c - FCYC - 2) / DIV); exp_b = 1'b1;
      end
      check("wave_tx", 32'(tx), 32'(exp_tx));
      check("wave_busy", 32'(tx_busy), 32'(exp_b));
      @(negedge clk);
    end
    check("wave_end_tx", 32'(tx), 32'd1);
    check("wave_end_busy", 32'(tx_busy), 32'd0);
  endtask

  // Serial monitor: samples mid-bit, compares each received byte to the scoreboard head.
  initial begin
    logic [7:0] data;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        check("mon_start_mid", 32'(tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          data[i] = tx;
        end
`ifdef UART_PARITY_EN
        repeat (DIV) @(negedge clk);
        check("mon_parity", 32'(tx), 32'(^data));
`endif
        repeat (DIV) @(negedge clk);
        check("mon_stop", 32'(tx), 32'd1);
        frames_seen++;
        if (sb.size() == 0) check("mon_unexpected_frame", {24'h0, data}, 32'hFFFF_FFFF);
        else check("mon_byte", {24'h0, data}, {24'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int low_cnt;
    chk_cnt = 0; pass_cnt = 0; frames_seen = 0; mon_en = 1'b0;
    rst_n = 1'b0; we = 1'b0; a = '0; wd = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_status", BASE + 32'h4, 32'h2);

    // Reset mid-frame with a byte still queued
    store(BASE, 32'h00);
    store(BASE, 32'h00);
    repeat (8) @(negedge clk);
    check("pre_reset_tx_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(tx), 32'd1);
    check("midframe_rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("post_rst_status", BASE + 32'h4, 32'h2);
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) low_cnt++;
    end
    check("post_rst_quiet_cycles", 32'(low_cnt), 32'd0);

    mon_en = 1'b1;

    // Single-frame waveform plus back-to-back gap
    burst2_check(8'h55, 8'hA3);
    // Parity-relevant bytes (odd and even weight)
    burst2_check(8'h07, 8'h03);

    // FIFO fill with overflow on the sixth consecutive store
    for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      we = 1'b1; a = BASE; wd = 32'(i);
    end
    @(negedge clk);
    we = 1'b0;
    rd_chk("fill_status", BASE + 32'h4, 32'hD);
    drain(3000);
    rd_chk("drained_status_ovf", BASE + 32'h4, 32'hA);

    // Overflow clear
    store(BASE + 32'h4, 32'h0);
    rd_chk("ovf_kept_on_zero", BASE + 32'h4, 32'hA);
    store(BASE + 32'h4, 32'h8);
    rd_chk("ovf_cleared", BASE + 32'h4, 32'h2);
    store(BASE + 32'h4, 32'h0);
    rd_chk("ovf_clear_no_change", BASE + 32'h4, 32'h2);

    // Decode boundaries
    @(negedge clk);
    we = 1'b1; a = BASE + 32'h8; wd = 32'hAA;
    #1;
    check("dec_hi_hit", 32'(hit), 32'd0);
    check("dec_hi_rd", rd, 32'd0);
    @(negedge clk);
    a = BASE - 32'h4; wd = 32'hBB;
    #1;
    check("dec_lo_hit", 32'(hit), 32'd0);
    check("dec_lo_rd", rd, 32'd0);
    @(negedge clk);
    we = 1'b0;
    rd_chk("dec_txdata_read", BASE, 32'd0);
    check("dec_txdata_hit", 32'(hit), 32'd1);
    rd_chk("dec_alias_status", BASE + 32'h7, 32'h2);
    repeat (20) @(negedge clk);
    check("dec_no_push_busy", 32'(tx_busy), 32'd0);
    rd_chk("dec_no_push_status", BASE + 32'h4, 32'h2);

    drain(200);
    check("frames_seen", 32'(frames_seen), 32'd9);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
